// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between fetch and decode.
// Circular FIFO with first-word fall-through pair output and NOP padding.
module inst_fetch_queue #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  logic [31:0]                in_inst_1,
    input  logic [31:0]                in_inst_2,
    output logic                       in_ready,
    output logic [31:0]                inst1,
    output logic [31:0]                inst2,
    output logic [1:0]                 out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FREE2 = CW'(DEPTH - 2);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];

    logic [AW-1:0] head_nx;
    logic [AW-1:0] tail_nx;
    logic          push_en;
    logic [1:0]    n_push;
    logic [1:0]    n_pop;
    logic [1:0]    vld;

    assign head_nx = head_q + AW'(1);
    assign tail_nx = tail_q + AW'(1);

    // Handshake and output slots; flush masks everything presented to decode
    always_comb begin
        in_ready  = (count_q <= FREE2);
        vld       = {count_q >= CW'(2), count_q >= CW'(1)};
        out_valid = flush ? 2'b00 : vld;
        inst1     = out_valid[0] ? mem_q[head_q]  : NOP;
        inst2     = out_valid[1] ? mem_q[head_nx] : NOP;
        count     = count_q;
        push_en   = in_ready && in_valid[0] && !flush;
        n_push    = push_en ? (in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
        n_pop     = 2'd0;
        if (out_ready && !flush) begin
            n_pop = {1'b0, vld[0]} + {1'b0, vld[1]};
        end
    end

    // Next-state for pointers, occupancy and storage
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_en) begin
                mem_d[tail_q] = in_inst_1;
                if (in_valid[1]) begin
                    mem_d[tail_nx] = in_inst_2;
                end
            end
            head_d  = head_q + AW'(n_pop);
            tail_d  = tail_q + AW'(n_push);
            count_d = count_q + CW'(n_push) - CW'(n_pop);
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
